// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller signal bundle between hazard/EX logic and the PC register
interface fetch_ctrl_if;
  logic [31:0] pc;
  logic        stall;
  logic        pred_taken_if;
  logic        br_ex_valid;
  logic        br_ex_taken;
  logic        br_ex_pred;
  logic [31:0] br_ex_pc;
  logic [31:0] br_ex_target;
  logic        jalr_ex;
  logic [2:0]  pcsrc;
  logic        br_pred_taken;
  logic [31:0] restore_addr;
  logic        flush_if;
  logic        flush_id;
  logic        fetch_valid;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  modport master (
    output pc, stall, pred_taken_if, br_ex_valid, br_ex_taken, br_ex_pred,
           br_ex_pc, br_ex_target, jalr_ex,
    input  pcsrc, br_pred_taken, restore_addr, flush_if, flush_id,
           fetch_valid, br_count, mispred_count
  );

  modport slave (
    input  pc, stall, pred_taken_if, br_ex_valid, br_ex_taken, br_ex_pred,
           br_ex_pc, br_ex_target, jalr_ex,
    output pcsrc, br_pred_taken, restore_addr, flush_if, flush_id,
           fetch_valid, br_count, mispred_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage next-PC sequencing: boot hold, stalls, redirects, squash, branch counters
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h4000_0000,
  parameter int          BOOT_CYCLES   = 2,
  parameter int          SQUASH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_SQUASH} state_t;

  localparam logic [2:0] PCSRC_RESET   = 3'd0;
  localparam logic [2:0] PCSRC_ALU     = 3'd1;
  localparam logic [2:0] PCSRC_PC4     = 3'd2;
  localparam logic [2:0] PCSRC_RESTORE = 3'd4;
  localparam logic [3:0] BOOT_INIT     = 4'(BOOT_CYCLES - 1);
  localparam logic [2:0] SQ_RELOAD     = 3'(SQUASH_CYCLES);

  if (RESET_PC[1:0] != 2'b00 || BOOT_CYCLES < 1 || BOOT_CYCLES > 15 ||
      SQUASH_CYCLES < 1 || SQUASH_CYCLES > 7) begin : g_bad_params
    $error("fetch_ctrl: illegal parameter value");
  end

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_boot_cnt, w_boot_nxt;
  logic [2:0]  r_sq_cnt, w_sq_nxt;
  logic [31:0] r_br_count, r_mispred_count;

  logic        w_mispred;
  logic [2:0]  w_pcsrc;
  logic        w_bp_taken;
  logic [31:0] w_restore;
  logic        w_flush;
  logic        w_fetch_valid;

  assign w_mispred = bus.br_ex_valid && (bus.br_ex_taken != bus.br_ex_pred);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_boot_cnt <= BOOT_INIT;
      r_sq_cnt   <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_boot_nxt;
      r_sq_cnt   <= w_sq_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_boot_nxt    = r_boot_cnt;
    w_sq_nxt      = r_sq_cnt;
    w_pcsrc       = PCSRC_PC4;
    w_bp_taken    = 1'b0;
    w_restore     = bus.pc;
    w_flush       = 1'b0;
    w_fetch_valid = 1'b0;
    if (rst) begin
      w_pcsrc   = PCSRC_RESET;
      w_restore = 32'd0;
      w_flush   = 1'b1;
    end else begin
      case (r_state)
        S_BOOT: begin
          w_flush = 1'b1;
          if (r_boot_cnt == 4'd0) begin
            w_pcsrc     = PCSRC_PC4;
            w_state_nxt = S_RUN;
          end else begin
            w_pcsrc    = PCSRC_RESET;
            w_boot_nxt = r_boot_cnt - 4'd1;
          end
        end
        default: begin
          w_fetch_valid = (r_state == S_RUN) && !bus.stall;
          // Squash countdown runs regardless of stall; a redirect below overrides it.
          if (r_state == S_SQUASH) begin
            w_sq_nxt = r_sq_cnt - 3'd1;
            if (r_sq_cnt <= 3'd1) w_state_nxt = S_RUN;
          end
          if (w_mispred) begin
            w_pcsrc     = PCSRC_RESTORE;
            w_restore   = bus.br_ex_taken ? bus.br_ex_target : bus.br_ex_pc + 32'd4;
            w_flush     = 1'b1;
            w_state_nxt = S_SQUASH;
            w_sq_nxt    = SQ_RELOAD;
          end else if (bus.jalr_ex) begin
            w_pcsrc     = PCSRC_ALU;
            w_flush     = 1'b1;
            w_state_nxt = S_SQUASH;
            w_sq_nxt    = SQ_RELOAD;
          end else if (bus.stall) begin
            w_pcsrc = PCSRC_RESTORE;
          end else begin
            w_pcsrc    = PCSRC_PC4;
            w_bp_taken = bus.pred_taken_if;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count <= 32'd0;
    end else if (r_state != S_BOOT && bus.br_ex_valid) begin
      r_br_count <= r_br_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispred_count <= 32'd0;
    end else if (r_state != S_BOOT && w_mispred) begin
      r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign bus.pcsrc         = w_pcsrc;
  assign bus.br_pred_taken = w_bp_taken;
  assign bus.restore_addr  = w_restore;
  assign bus.flush_if      = w_flush;
  assign bus.flush_id      = w_flush;
  assign bus.fetch_valid   = w_fetch_valid;
  assign bus.br_count      = r_br_count;
  assign bus.mispred_count = r_mispred_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a cycle-count reference model
module tb_fetch_ctrl;
  localparam int BOOT_CYCLES   = 2;
  localparam int SQUASH_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if bus_if ();

  fetch_ctrl #(
    .RESET_PC(32'h4000_0000), .BOOT_CYCLES(BOOT_CYCLES), .SQUASH_CYCLES(SQUASH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining boot slots, remaining squashed slots, counters.
  int          m_boot_left;
  int          m_sq_left;
  logic [31:0] m_bcnt, m_mcnt;
  logic [2:0]  e_pcsrc;
  logic        e_bp, e_flush, e_fv;
  logic [31:0] e_restore;

  function automatic logic [102:0] act_vec();
    return {bus_if.pcsrc, bus_if.br_pred_taken, bus_if.restore_addr, bus_if.flush_if,
            bus_if.flush_id, bus_if.fetch_valid, bus_if.br_count, bus_if.mispred_count};
  endfunction

  function automatic logic [102:0] exp_vec();
    return {e_pcsrc, e_bp, e_restore, e_flush, e_flush, e_fv, m_bcnt, m_mcnt};
  endfunction

  task automatic model_eval();
    logic mis;
    mis = bus_if.br_ex_valid && (bus_if.br_ex_taken != bus_if.br_ex_pred);
    e_bp = 1'b0; e_flush = 1'b0; e_fv = 1'b0; e_restore = bus_if.pc; e_pcsrc = 3'd2;
    if (rst) begin
      e_pcsrc = 3'd0; e_flush = 1'b1; e_restore = 32'd0;
    end else if (m_boot_left > 0) begin
      e_pcsrc = (m_boot_left == 1) ? 3'd2 : 3'd0;
      e_flush = 1'b1;
    end else begin
      e_fv = (m_sq_left == 0) && !bus_if.stall;
      if (mis) begin
        e_pcsrc = 3'd4; e_flush = 1'b1;
        e_restore = bus_if.br_ex_taken ? bus_if.br_ex_target : bus_if.br_ex_pc + 32'd4;
      end else if (bus_if.jalr_ex) begin
        e_pcsrc = 3'd1; e_flush = 1'b1;
      end else if (bus_if.stall) begin
        e_pcsrc = 3'd4;
      end else begin
        e_bp = bus_if.pred_taken_if;
      end
    end
  endtask

  task automatic model_advance();
    logic mis;
    mis = bus_if.br_ex_valid && (bus_if.br_ex_taken != bus_if.br_ex_pred);
    if (rst) begin
      m_boot_left = BOOT_CYCLES; m_sq_left = 0; m_bcnt = 0; m_mcnt = 0;
    end else if (m_boot_left > 0) begin
      m_boot_left--;
    end else begin
      if (bus_if.br_ex_valid) m_bcnt = m_bcnt + 32'd1;
      if (mis) m_mcnt = m_mcnt + 32'd1;
      if (mis || bus_if.jalr_ex) m_sq_left = SQUASH_CYCLES;
      else if (m_sq_left > 0) m_sq_left--;
    end
  endtask

  task automatic apply(input logic st, input logic pt, input logic bv, input logic bt,
                       input logic bp, input logic jl, input logic [31:0] p,
                       input logic [31:0] bpc, input logic [31:0] btg);
    bus_if.stall = st; bus_if.pred_taken_if = pt; bus_if.br_ex_valid = bv;
    bus_if.br_ex_taken = bt; bus_if.br_ex_pred = bp; bus_if.jalr_ex = jl;
    bus_if.pc = p; bus_if.br_ex_pc = bpc; bus_if.br_ex_target = btg;
    #1;
    model_eval();
  endtask

  task automatic idle(input logic [31:0] p);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, p, 32'd0, 32'd0);
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(32'h4000_0000);
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", act_vec(), exp_vec());
    end
    n_checks++;
    if (bus_if.pcsrc !== 3'd0 || bus_if.flush_id !== 1'b1) begin
      n_fail++; $display("FAIL reset_pcsrc: got %0d/%b want 0/1", bus_if.pcsrc, bus_if.flush_id);
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_boot();
    idle(32'h4000_0000);
    n_checks++;
    if (bus_if.pcsrc !== 3'd0 || bus_if.fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL boot_c0: got pcsrc %0d fv %b want 0 0", bus_if.pcsrc, bus_if.fetch_valid);
    end
    tick();
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4000_0000, 32'h0, 32'h0);
    n_checks++;
    if (bus_if.pcsrc !== 3'd2) begin
      n_fail++; $display("FAIL boot_c1: got pcsrc %0d want 2", bus_if.pcsrc);
    end
    tick();
    idle(32'h4000_0004);
    n_checks++;
    if (bus_if.fetch_valid !== 1'b1 || bus_if.br_count !== 32'd0) begin
      n_fail++; $display("FAIL boot_c2: got fv %b brc %0d want 1 0", bus_if.fetch_valid, bus_if.br_count);
    end
    tick();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000_0010, 32'h0, 32'h0);
      n_checks++;
      if (bus_if.pcsrc !== 3'd4 || bus_if.restore_addr !== 32'h4000_0010 ||
          bus_if.br_pred_taken !== 1'b0 || bus_if.flush_if !== 1'b0 || bus_if.flush_id !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold: got pcsrc %0d ra %h bp %b fl %b%b want 4 40000010 0 00",
                           bus_if.pcsrc, bus_if.restore_addr, bus_if.br_pred_taken,
                           bus_if.flush_if, bus_if.flush_id);
      end
      tick();
    end
    idle(32'h4000_0010);
    n_checks++;
    if (bus_if.pcsrc !== 3'd2) begin
      n_fail++; $display("FAIL stall_release: got pcsrc %0d want 2", bus_if.pcsrc);
    end
    tick();
  endtask

  task automatic test_mispredict();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4000_0030, 32'h4000_0020, 32'h4000_0200);
    n_checks++;
    if (bus_if.pcsrc !== 3'd4 || bus_if.restore_addr !== 32'h4000_0024 ||
        bus_if.flush_if !== 1'b1 || bus_if.flush_id !== 1'b1) begin
      n_fail++; $display("FAIL mispred_nt: got pcsrc %0d ra %h fl %b%b want 4 40000024 11",
                         bus_if.pcsrc, bus_if.restore_addr, bus_if.flush_if, bus_if.flush_id);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(32'h4000_0024 + 32'(4 * i));
      n_checks++;
      if (bus_if.fetch_valid !== (i == 2)) begin
        n_fail++; $display("FAIL mispred_squash[%0d]: got fv %b want %b", i, bus_if.fetch_valid, i == 2);
      end
      tick();
    end
    n_checks++;
    if (bus_if.mispred_count !== 32'd1 || bus_if.br_count !== 32'd1) begin
      n_fail++; $display("FAIL mispred_counts: got m %0d b %0d want 1 1", bus_if.mispred_count, bus_if.br_count);
    end
  endtask

  task automatic test_simultaneous();
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4000_0040, 32'h4000_0038, 32'h4000_0100);
    n_checks++;
    if (bus_if.pcsrc !== 3'd4 || bus_if.restore_addr !== 32'h4000_0100 || bus_if.br_pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL simul_redirect: got pcsrc %0d ra %h want 4 40000100", bus_if.pcsrc, bus_if.restore_addr);
    end
    tick();
    idle(32'h4000_0100); tick();
    idle(32'h4000_0104); tick();
  endtask

  task automatic test_jalr_squash();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0050, 32'h0, 32'h0);
    n_checks++;
    if (bus_if.pcsrc !== 3'd1 || bus_if.flush_if !== 1'b1) begin
      n_fail++; $display("FAIL jalr_run: got pcsrc %0d fl %b want 1 1", bus_if.pcsrc, bus_if.flush_if);
    end
    tick();
    idle(32'h4000_0300); tick();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0304, 32'h0, 32'h0);
    n_checks++;
    if (bus_if.pcsrc !== 3'd1 || bus_if.fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL jalr_squash: got pcsrc %0d fv %b want 1 0", bus_if.pcsrc, bus_if.fetch_valid);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(32'h4000_0400);
      n_checks++;
      if (bus_if.fetch_valid !== (i == 2)) begin
        n_fail++; $display("FAIL jalr_reload[%0d]: got fv %b want %b", i, bus_if.fetch_valid, i == 2);
      end
      tick();
    end
  endtask

  task automatic test_pred_taken();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000_0404, 32'h0, 32'h0);
    n_checks++;
    if (bus_if.br_pred_taken !== 1'b1 || bus_if.pcsrc !== 3'd2) begin
      n_fail++; $display("FAIL pred_taken: got bp %b pcsrc %0d want 1 2", bus_if.br_pred_taken, bus_if.pcsrc);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      apply($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
            1'($urandom), $urandom_range(0, 7) == 0, $urandom, $urandom, $urandom);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    rst = 1'b1; idle(32'h0); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin idle(32'h4000_0000); tick(); end
    force dut.r_mispred_count = 32'hFFFF_FFFF;
    idle(32'h4000_0010); tick();
    release dut.r_mispred_count;
    m_mcnt = 32'hFFFF_FFFF;
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_0014, 32'h4000_0010, 32'h4000_0800);
    tick();
    idle(32'h4000_0800);
    n_checks++;
    if (bus_if.mispred_count !== 32'd0) begin
      n_fail++; $display("FAIL mispred_wrap: got %h want 00000000", bus_if.mispred_count);
    end
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL wrap_state: got %h want %h", act_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_reset_mid_squash();
    for (int i = 0; i < 3; i++) begin idle(32'h4000_0000); tick(); end
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_0020, 32'h4000_001C, 32'h4000_0900);
    tick();
    rst = 1'b1;
    idle(32'h4000_0900);
    n_checks++;
    if (bus_if.pcsrc !== 3'd0 || bus_if.restore_addr !== 32'd0 || bus_if.fetch_valid !== 1'b0 ||
        bus_if.flush_if !== 1'b1) begin
      n_fail++; $display("FAIL rst_forced: got pcsrc %0d ra %h fv %b fl %b want 0 0 0 1",
                         bus_if.pcsrc, bus_if.restore_addr, bus_if.fetch_valid, bus_if.flush_if);
    end
    tick();
    rst = 1'b0;
    idle(32'h4000_0904);
    n_checks++;
    if (bus_if.pcsrc !== 3'd0 || bus_if.br_count !== 32'd0 || bus_if.mispred_count !== 32'd0 ||
        bus_if.fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_squash: got pcsrc %0d b %0d m %0d fv %b want 0 0 0 0",
                         bus_if.pcsrc, bus_if.br_count, bus_if.mispred_count, bus_if.fetch_valid);
    end
    tick();
  endtask

  initial begin
    m_boot_left = BOOT_CYCLES; m_sq_left = 0; m_bcnt = 0; m_mcnt = 0;
    @(negedge clk);
    test_reset();
    test_boot();
    test_stall();
    test_mispredict();
    test_simultaneous();
    test_jalr_squash();
    test_pred_taken();
    test_random();
    test_wrap();
    test_reset_mid_squash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the IF-stage PC register. Each cycle it selects the next-PC source (pcsrc), gates the branch-predictor redirect, and supplies the restore address.
- Handles boot hold, load-use stalls, JALR redirects and branch-mispredict recovery.
- Squashes the wrong-path fetches and counts resolved and mispredicted branches.
- Sits between the hazard unit, the EX-stage branch resolution and the PC register.

Parameters:
- RESET_PC, 32'h4000_0000, boot fetch address; reported only for debug.
- BOOT_CYCLES, 2, cycles the PC is held at RESET_PC after reset release (1..15).
- SQUASH_CYCLES, 2, fetch slots invalidated after any EX-stage redirect (1..7); matches IMEM read latency plus IF/ID depth.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  current PC register value.
- stall  in  1  hazard unit requests the fetch be held.
- pred_taken_if  in  1  predictor says the instruction in IF is a taken branch.
- br_ex_valid  in  1  conditional branch resolved in EX this cycle.
- br_ex_taken  in  1  actual outcome.
- br_ex_pred  in  1  prediction carried down the pipe with that branch.
- br_ex_pc  in  32  PC of the resolving branch.
- br_ex_target  in  32  computed branch target.
- jalr_ex  in  1  JALR in EX; target is on the PC register's ALU input.
- pcsrc  out  3  1 = ALU address, 2 = PC+4, 4 = restore address, 0 = RESET_PC.
- br_pred_taken  out  1  gated predictor redirect to the PC register.
- restore_addr  out  32  address used when pcsrc = 4.
- flush_if  out  1  kill the IF/ID register contents.
- flush_id  out  1  kill the ID/EX register contents.
- fetch_valid  out  1  the instruction being fetched this cycle is architecturally valid.
- br_count  out  32  resolved conditional branches.
- mispred_count  out  32  mispredicted branches.

Behaviour:
- State is registered; outputs are combinational from state and current inputs.
- States:
  - BOOT: initial state.
  - RUN: normal fetch.
  - SQUASH: wrong-path slots are being discarded after a redirect.
- Reset (rst = 1 at an edge):
  - Next state BOOT; boot counter = BOOT_CYCLES-1; squash counter = 0; br_count = 0; mispred_count = 0.
  - While rst is high, outputs are forced: pcsrc = 0, br_pred_taken = 0, flush_if = flush_id = 1, fetch_valid = 0, restore_addr = 0.
  - Reset mid-operation (any state) aborts immediately; it wins over every other input.
- BOOT:
  - pcsrc = 0, fetch_valid = 0, flush_if = flush_id = 1.
  - Boot counter decrements each cycle. In the cycle it reads 0: pcsrc = 2, and the state moves to RUN.
  - In BOOT, stall, jalr_ex, br_ex_valid and pred_taken_if are ignored.
- Define mispred = br_ex_valid && (br_ex_taken != br_ex_pred).
- RUN and SQUASH share one priority chain, highest first:
  1. mispred:
     - pcsrc = 4; restore_addr = br_ex_taken ? br_ex_target : br_ex_pc + 4 (32-bit wrap).
     - flush_if = flush_id = 1; br_pred_taken = 0.
     - Next state SQUASH; squash counter = SQUASH_CYCLES.
  2. jalr_ex: pcsrc = 1, flush_if = flush_id = 1, br_pred_taken = 0; next state SQUASH with the counter reloaded.
  3. stall: pcsrc = 4, restore_addr = pc (replay), br_pred_taken = 0, no flush.
  4. Otherwise: pcsrc = 2, br_pred_taken = pred_taken_if.
- When none of rules 1 or 2 fires, restore_addr = pc.
- stall coincident with mispred or jalr_ex is ignored; the redirect wins.
- SQUASH:
  - fetch_valid = 0.
  - The squash counter decrements every cycle, including during a stall.
  - Leaving SQUASH: the next-state decision is made on the cycle the counter reads 1, so the state changes to RUN on the following edge; fetch_valid is 1 from that cycle on.
  - A new redirect while in SQUASH reloads the counter to SQUASH_CYCLES.
- RUN: fetch_valid = !stall.
- Counters:
  - br_count increments on every br_ex_valid in RUN or SQUASH.
  - mispred_count increments on every mispred.
  - Both are 32-bit and wrap from FFFF_FFFF to 0; neither updates in BOOT or during reset.
- The pcsrc output never takes values 3, 5, 6 or 7.

Test Plan:
- Reset, then release with BOOT_CYCLES = 2:
  - Cycle 0: pcsrc = 0, fetch_valid = 0.
  - Cycle 1: pcsrc = 2.
  - Cycle 2: state RUN, fetch_valid = 1.
- RUN, pc = 0x4000_0010, stall = 1 for 3 cycles -> pcsrc = 4, restore_addr = 0x4000_0010, br_pred_taken = 0, no flush; then pcsrc = 2.
- Mispredict not-taken: br_ex_valid = 1, br_ex_taken = 0, br_ex_pred = 1, br_ex_pc = 0x4000_0020 ->
  - pcsrc = 4, restore_addr = 0x4000_0024, flush_if = flush_id = 1.
  - fetch_valid = 0 for 2 cycles; mispred_count = 1, br_count = 1.
- Simultaneous mispredict (taken, br_ex_target = 0x4000_0100), jalr_ex and stall -> pcsrc = 4, restore_addr = 0x4000_0100, stall ignored.
- jalr_ex during SQUASH with 1 cycle left -> counter reloads to 2; fetch_valid stays 0 for 2 more cycles.
- pred_taken_if = 1 in RUN with no hazards -> br_pred_taken = 1, pcsrc = 2.
- Preload mispred_count = FFFF_FFFF (force), then one mispredict -> mispred_count = 0.
- rst asserted mid-SQUASH -> next cycle pcsrc = 0, state BOOT, both counters = 0.
